// File: rtl/riscv_pkg.sv
// RV32I opcode constants, immediate format tags and register-use decode
// shared by the operand fetch stage and its immediate generator.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic      use_rs1;
    logic      use_rs2;
    logic      writes_rd;
    logic      is_load;
    imm_type_e imm_type;
  } inst_info_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode inside {OP, STORE, BRANCH, OP_IMM, LOAD, JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OP, STORE, BRANCH};
  endfunction

  // Unknown opcodes fall through to "no sources, no rd write, no immediate".
  function automatic inst_info_t decode_inst(input logic [6:0] opcode);
    inst_info_t info;
    info.use_rs1   = uses_rs1(opcode);
    info.use_rs2   = uses_rs2(opcode);
    info.is_load   = (opcode == LOAD);
    info.writes_rd = opcode inside {OP, OP_IMM, LOAD, JALR, JAL, LUI, AUIPC, SYSTEM};
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: info.imm_type = IMM_I;
      STORE:                      info.imm_type = IMM_S;
      BRANCH:                     info.imm_type = IMM_B;
      LUI, AUIPC:                 info.imm_type = IMM_U;
      JAL:                        info.imm_type = IMM_J;
      default:                    info.imm_type = IMM_NONE;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_imm_gen.sv
// Combinational RV32I immediate generator; only Inst[31:7] carries
// immediate bits, so the opcode field is not brought in.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:7] Inst,
  input  imm_type_e       Imm_Type,
  output logic [XLEN-1:0] Imm
);

  always_comb begin
    Imm = '0;
    case (Imm_Type)
      IMM_I:   Imm = {{20{Inst[31]}}, Inst[31:20]};
      IMM_S:   Imm = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
      IMM_B:   Imm = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
      IMM_U:   Imm = {Inst[31:12], 12'b0};
      IMM_J:   Imm = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
      default: Imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: reads register_file, bypasses writeback,
// builds the immediate, stalls on load-use and holds one result for execute.
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Flush,
  input  logic              Inst_Valid,
  output logic              Inst_Ready,
  input  logic [XLEN-1:0]   Inst,
  input  logic [XLEN-1:0]   Inst_Pc,
  output logic [REG_AW-1:0] Rf_Read_Addr_1,
  input  logic [XLEN-1:0]   Rf_Read_Data_1,
  output logic [REG_AW-1:0] Rf_Read_Addr_2,
  input  logic [XLEN-1:0]   Rf_Read_Data_2,
  input  logic              Wb_Wr_En,
  input  logic [REG_AW-1:0] Wb_Write_Addr,
  input  logic [XLEN-1:0]   Wb_Write_Data,
  input  logic              Ex_Valid,
  input  logic              Ex_Is_Load,
  input  logic [REG_AW-1:0] Ex_Rd,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [XLEN-1:0]   Out_Pc,
  output logic [XLEN-1:0]   Out_Inst,
  output logic [XLEN-1:0]   Out_Rs1_Data,
  output logic [XLEN-1:0]   Out_Rs2_Data,
  output logic [XLEN-1:0]   Out_Imm,
  output logic [REG_AW-1:0] Out_Rd,
  output logic              Out_Rd_Wr,
  output logic              Out_Is_Load
);

  import riscv_pkg::*;

  inst_info_t        new_info;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [REG_AW-1:0] held_rs1, held_rs2;
  logic [XLEN-1:0]   rs1_data, rs2_data, imm;
  logic              hit1, hit2, stall, fire;
  logic              refresh1, refresh2;

  assign rs1      = Inst[19:15];
  assign rs2      = Inst[24:20];
  assign rd       = Inst[11:7];
  assign held_rs1 = Out_Inst[19:15];
  assign held_rs2 = Out_Inst[24:20];
  assign new_info = decode_inst(Inst[6:0]);

  assign Rf_Read_Addr_1 = rs1;
  assign Rf_Read_Addr_2 = rs2;

  // register_file commits on the same edge we capture, so a same-cycle write must be forwarded.
  always_comb begin
    rs1_data = Rf_Read_Data_1;
    if (rs1 == '0)
      rs1_data = '0;
    else if (Wb_Wr_En && Wb_Write_Addr == rs1)
      rs1_data = Wb_Write_Data;
    rs2_data = Rf_Read_Data_2;
    if (rs2 == '0)
      rs2_data = '0;
    else if (Wb_Wr_En && Wb_Write_Addr == rs2)
      rs2_data = Wb_Write_Data;
  end

  // A load either in execute or still sitting in our output register cannot be forwarded yet.
  assign hit1 = new_info.use_rs1 && (rs1 != '0) &&
                ((Ex_Valid && Ex_Is_Load && Ex_Rd == rs1) ||
                 (Out_Valid && Out_Is_Load && Out_Rd == rs1));
  assign hit2 = new_info.use_rs2 && (rs2 != '0) &&
                ((Ex_Valid && Ex_Is_Load && Ex_Rd == rs2) ||
                 (Out_Valid && Out_Is_Load && Out_Rd == rs2));
  assign stall = Inst_Valid && (hit1 || hit2);

  assign Inst_Ready = !Rst_Core && !Flush && !stall && (!Out_Valid || Out_Ready);
  assign fire       = Inst_Valid && Inst_Ready;

  assign refresh1 = Out_Valid && !Out_Ready && Wb_Wr_En && (Wb_Write_Addr != '0) &&
                    uses_rs1(Out_Inst[6:0]) && (Wb_Write_Addr == held_rs1);
  assign refresh2 = Out_Valid && !Out_Ready && Wb_Wr_En && (Wb_Write_Addr != '0) &&
                    uses_rs2(Out_Inst[6:0]) && (Wb_Write_Addr == held_rs2);

  imm_gen u_imm_gen (
    .Inst     (Inst[XLEN-1:7]),
    .Imm_Type (new_info.imm_type),
    .Imm      (imm)
  );

  // Flush beats a new fire; a stalled result keeps tracking writebacks to its sources.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      Out_Valid    <= 1'b0;
      Out_Pc       <= '0;
      Out_Inst     <= '0;
      Out_Rs1_Data <= '0;
      Out_Rs2_Data <= '0;
      Out_Imm      <= '0;
      Out_Rd       <= '0;
      Out_Rd_Wr    <= 1'b0;
      Out_Is_Load  <= 1'b0;
    end else if (Flush) begin
      Out_Valid <= 1'b0;
    end else if (fire) begin
      Out_Valid    <= 1'b1;
      Out_Pc       <= Inst_Pc;
      Out_Inst     <= Inst;
      Out_Rs1_Data <= rs1_data;
      Out_Rs2_Data <= rs2_data;
      Out_Imm      <= imm;
      Out_Rd       <= rd;
      Out_Rd_Wr    <= new_info.writes_rd && (rd != '0);
      Out_Is_Load  <= new_info.is_load;
    end else if (Out_Valid && Out_Ready) begin
      Out_Valid <= 1'b0;
    end else begin
      if (refresh1)
        Out_Rs1_Data <= Wb_Write_Data;
      if (refresh2)
        Out_Rs2_Data <= Wb_Write_Data;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed RV32I vectors push
// hand-computed results, a monitor pops and compares on every transfer.
module tb_operand_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_wr;
    logic        is_load;
  } exp_t;

  logic        Clk_Core, Rst_Core, Flush;
  logic        Inst_Valid, Inst_Ready;
  logic [31:0] Inst, Inst_Pc;
  logic [4:0]  Rf_Read_Addr_1, Rf_Read_Addr_2;
  logic [31:0] Rf_Read_Data_1, Rf_Read_Data_2;
  logic        Wb_Wr_En;
  logic [4:0]  Wb_Write_Addr;
  logic [31:0] Wb_Write_Data;
  logic        Ex_Valid, Ex_Is_Load;
  logic [4:0]  Ex_Rd;
  logic        Out_Valid, Out_Ready;
  logic [31:0] Out_Pc, Out_Inst, Out_Rs1_Data, Out_Rs2_Data, Out_Imm;
  logic [4:0]  Out_Rd;
  logic        Out_Rd_Wr, Out_Is_Load;

  exp_t sb[$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  operand_fetch_stage dut (
    .Clk_Core       (Clk_Core),
    .Rst_Core       (Rst_Core),
    .Flush          (Flush),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .Inst           (Inst),
    .Inst_Pc        (Inst_Pc),
    .Rf_Read_Addr_1 (Rf_Read_Addr_1),
    .Rf_Read_Data_1 (Rf_Read_Data_1),
    .Rf_Read_Addr_2 (Rf_Read_Addr_2),
    .Rf_Read_Data_2 (Rf_Read_Data_2),
    .Wb_Wr_En       (Wb_Wr_En),
    .Wb_Write_Addr  (Wb_Write_Addr),
    .Wb_Write_Data  (Wb_Write_Data),
    .Ex_Valid       (Ex_Valid),
    .Ex_Is_Load     (Ex_Is_Load),
    .Ex_Rd          (Ex_Rd),
    .Out_Valid      (Out_Valid),
    .Out_Ready      (Out_Ready),
    .Out_Pc         (Out_Pc),
    .Out_Inst       (Out_Inst),
    .Out_Rs1_Data   (Out_Rs1_Data),
    .Out_Rs2_Data   (Out_Rs2_Data),
    .Out_Imm        (Out_Imm),
    .Out_Rd         (Out_Rd),
    .Out_Rd_Wr      (Out_Rd_Wr),
    .Out_Is_Load    (Out_Is_Load)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic rdWr, input logic isLoad);
    exp_t e;
    e.pc = pc; e.inst = inst; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.rd = rd; e.rd_wr = rdWr; e.is_load = isLoad;
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic idleInputs();
    Inst_Valid = 1'b0;
    Wb_Wr_En   = 1'b0;
    Flush      = 1'b0;
  endtask

  // Presents one instruction, waits (bounded) for acceptance, then returns just after the load edge.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rf1, input logic [31:0] rf2,
                               input logic wbEn, input logic [4:0] wbAddr, input logic [31:0] wbData,
                               input bit push, input exp_t e);
    bit fired;
    Inst = inst; Inst_Pc = pc;
    Rf_Read_Data_1 = rf1; Rf_Read_Data_2 = rf2;
    Wb_Wr_En = wbEn; Wb_Write_Addr = wbAddr; Wb_Write_Data = wbData;
    Inst_Valid = 1'b1;
    fired = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk_Core);
      if (Inst_Ready) begin
        fired = 1'b1;
        break;
      end
    end
    if (!fired) checkOutput("issue_timeout", 32'd0, 32'd1);
    if (fired && push) sb.push_back(e);
    tick();
  endtask

  // Monitor: every accepted output must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge Clk_Core);
      if (!Rst_Core && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          monE = sb.pop_front();
          checkOutput("out_pc",      Out_Pc,            monE.pc);
          checkOutput("out_inst",    Out_Inst,          monE.inst);
          checkOutput("out_rs1",     Out_Rs1_Data,      monE.rs1);
          checkOutput("out_rs2",     Out_Rs2_Data,      monE.rs2);
          checkOutput("out_imm",     Out_Imm,           monE.imm);
          checkOutput("out_rd",      32'(Out_Rd),       32'(monE.rd));
          checkOutput("out_rd_wr",   32'(Out_Rd_Wr),    32'(monE.rd_wr));
          checkOutput("out_is_load", 32'(Out_Is_Load),  32'(monE.is_load));
        end
      end
    end
  end

  initial begin
    Rst_Core = 1'b1; Flush = 1'b0; Out_Ready = 1'b1;
    Inst_Valid = 1'b1; Inst = 32'h002081B3; Inst_Pc = 32'hFC;
    Rf_Read_Data_1 = 32'h11; Rf_Read_Data_2 = 32'h22;
    Wb_Wr_En = 1'b0; Wb_Write_Addr = '0; Wb_Write_Data = '0;
    Ex_Valid = 1'b0; Ex_Is_Load = 1'b0; Ex_Rd = '0;

    // Reset state, with a valid instruction presented that must not be taken.
    tick();
    tick();
    @(negedge Clk_Core);
    checkOutput("reset_inst_ready", 32'(Inst_Ready),   32'd0);
    checkOutput("reset_out_valid",  32'(Out_Valid),    32'd0);
    checkOutput("reset_out_pc",     Out_Pc,            32'd0);
    checkOutput("reset_out_inst",   Out_Inst,          32'd0);
    checkOutput("reset_out_rs1",    Out_Rs1_Data,      32'd0);
    checkOutput("reset_out_imm",    Out_Imm,           32'd0);
    checkOutput("reset_out_rd_wr",  32'(Out_Rd_Wr),    32'd0);
    checkOutput("rf_addr_1",        32'(Rf_Read_Addr_1), 32'd1);
    checkOutput("rf_addr_2",        32'(Rf_Read_Addr_2), 32'd2);
    tick();
    Rst_Core = 1'b0;
    idleInputs();
    tick();

    // ADDI x5,x0,7 then ADD x3,x1,x2 back to back with a same-cycle writeback of x2.
    applyStimulus(32'h00700293, 32'h100, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h100, 32'h00700293, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1, 1'b0));
    applyStimulus(32'h002081B3, 32'h104, 32'h10, 32'h20, 1'b1, 5'd2, 32'h99, 1'b1,
                  mk(32'h104, 32'h002081B3, 32'h10, 32'h99, 32'h0, 5'd3, 1'b1, 1'b0));
    idleInputs();
    @(negedge Clk_Core);
    checkOutput("latency_valid", 32'(Out_Valid), 32'd1);
    tick();

    // SW x2,12(x1); LUI x7,0x12345; JAL x1,8.
    applyStimulus(32'h0020A623, 32'h108, 32'h1000, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h108, 32'h0020A623, 32'h1000, 32'h77, 32'd12, 5'd12, 1'b0, 1'b0));
    applyStimulus(32'h123453B7, 32'h10C, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h10C, 32'h123453B7, 32'h0, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0));
    applyStimulus(32'h008000EF, 32'h110, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h110, 32'h008000EF, 32'h0, 32'h0, 32'd8, 5'd1, 1'b1, 1'b0));
    idleInputs();
    tick();
    tick();

    // LW x4,0(x1) followed by dependent ADD x6,x4,x4.
    applyStimulus(32'h0000A203, 32'h114, 32'h2000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h114, 32'h0000A203, 32'h2000, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1));
    Inst = 32'h00420333; Inst_Pc = 32'h118;
    Rf_Read_Data_1 = 32'h44; Rf_Read_Data_2 = 32'h44;
    Inst_Valid = 1'b1;
    @(negedge Clk_Core);
    checkOutput("stall_out_load", 32'(Inst_Ready), 32'd0);
    tick();
    Ex_Valid = 1'b1; Ex_Is_Load = 1'b1; Ex_Rd = 5'd4;
    @(negedge Clk_Core);
    checkOutput("stall_ex_load", 32'(Inst_Ready), 32'd0);
    checkOutput("lw_drained",    32'(Out_Valid),  32'd0);
    tick();
    Ex_Valid = 1'b0; Ex_Is_Load = 1'b0;
    applyStimulus(32'h00420333, 32'h118, 32'h44, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h118, 32'h00420333, 32'h44, 32'h44, 32'h0, 5'd6, 1'b1, 1'b0));
    idleInputs();
    tick();
    @(negedge Clk_Core);
    checkOutput("no_duplicate", 32'(Out_Valid), 32'd0);
    tick();

    // Held ADD x3,x1,x2 picks up a writeback of x1; disabled write to x2 is ignored.
    Out_Ready = 1'b0;
    applyStimulus(32'h002081B3, 32'h11C, 32'h10, 32'h20, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h11C, 32'h002081B3, 32'hABCD, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0));
    idleInputs();
    Wb_Wr_En = 1'b1; Wb_Write_Addr = 5'd1; Wb_Write_Data = 32'hABCD;
    @(negedge Clk_Core);
    checkOutput("held_before", Out_Rs1_Data, 32'h10);
    tick();
    Wb_Wr_En = 1'b0; Wb_Write_Addr = 5'd2; Wb_Write_Data = 32'hBAD;
    @(negedge Clk_Core);
    checkOutput("held_refresh_rs1", Out_Rs1_Data,    32'hABCD);
    checkOutput("held_rs2_keep",    Out_Rs2_Data,    32'h20);
    checkOutput("held_valid",       32'(Out_Valid),  32'd1);
    tick();
    Out_Ready = 1'b1;
    tick();
    @(negedge Clk_Core);
    checkOutput("single_transfer", 32'(Out_Valid), 32'd0);
    tick();

    // Flush while a result is held and a new instruction is offered.
    Out_Ready = 1'b0;
    applyStimulus(32'h00700293, 32'h120, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    Inst = 32'h002081B3; Inst_Pc = 32'h124;
    Rf_Read_Data_1 = 32'h10; Rf_Read_Data_2 = 32'h20;
    Inst_Valid = 1'b1; Flush = 1'b1;
    @(negedge Clk_Core);
    checkOutput("flush_ready", 32'(Inst_Ready), 32'd0);
    tick();
    Out_Ready = 1'b1;
    @(negedge Clk_Core);
    checkOutput("flush_kill",       32'(Out_Valid),  32'd0);
    checkOutput("flush_ready_idle", 32'(Inst_Ready), 32'd0);
    tick();
    Flush = 1'b0;
    applyStimulus(32'h002081B3, 32'h124, 32'h10, 32'h20, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h124, 32'h002081B3, 32'h10, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0));
    idleInputs();
    tick();

    // BEQ x0,x0,-8 with a writeback aimed at x0, first flowing then held.
    applyStimulus(32'hFE000CE3, 32'h128, 32'h5555, 32'h5555, 1'b1, 5'd0, 32'hDEAD, 1'b1,
                  mk(32'h128, 32'hFE000CE3, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0));
    idleInputs();
    tick();
    Out_Ready = 1'b0;
    applyStimulus(32'hFE000CE3, 32'h12C, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h12C, 32'hFE000CE3, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0));
    idleInputs();
    Wb_Wr_En = 1'b1; Wb_Write_Addr = 5'd0; Wb_Write_Data = 32'hDEAD;
    tick();
    Wb_Wr_En = 1'b0;
    @(negedge Clk_Core);
    checkOutput("x0_no_refresh_rs1", Out_Rs1_Data, 32'h0);
    checkOutput("x0_no_refresh_rs2", Out_Rs2_Data, 32'h0);
    tick();
    Out_Ready = 1'b1;
    tick();
    tick();

    // Reset while a result is held discards it.
    Out_Ready = 1'b0;
    applyStimulus(32'h00700293, 32'h130, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    idleInputs();
    Rst_Core = 1'b1;
    Inst_Valid = 1'b1;
    @(negedge Clk_Core);
    checkOutput("reset_ready_mid", 32'(Inst_Ready), 32'd0);
    tick();
    Rst_Core = 1'b0;
    Inst_Valid = 1'b0;
    @(negedge Clk_Core);
    checkOutput("reset_discard", 32'(Out_Valid), 32'd0);
    checkOutput("reset_pc_mid",  Out_Pc,         32'd0);
    tick();
    Out_Ready = 1'b1;
    applyStimulus(32'h00700293, 32'h134, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                  mk(32'h134, 32'h00700293, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1, 1'b0));
    idleInputs();
    tick();
    tick();
    tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
